alu_wave_gather: RTL

Parametrised wavefront gather buffer for the ALU writeback path. It collects PASSES narrow beats of LANES lanes each into one full-wavefront word plus a matching lane mask. It adds beat counting, valid/ready handshakes on both sides, and early-termination padding, so a short wavefront still lands at slot 0. It sits between the ALU pass sequencer and the VGPR/SGPR writeback arbiter.

---
 rtl/alu_wave_pkg.sv | 27 ++
 rtl/alu_wave_gather_reg.sv | 17 +
 rtl/alu_wave_gather.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_wave_pkg.sv
// Shared types and sizing helpers for the ALU wavefront gather buffer.
package alu_wave_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // beat_cnt must hold the value PASSES itself, hence the extra bit.
  function automatic int beat_cnt_w(input int passes);
    return clog2(passes) + 1;
  endfunction

  localparam int PASSES_DEFAULT = 4;
  localparam int BEAT_CNT_W     = beat_cnt_w(PASSES_DEFAULT);

endpackage

// File: rtl/alu_wave_gather_reg.sv
// Generic enable register with synchronous active-high clear.
module alu_wave_gather_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/alu_wave_gather.sv
// Gathers PASSES narrow ALU beats into one wavefront word plus lane mask,
// padding short wavefronts with zero beats so beat 0 always lands in slot 0.
//
// state | meaning
// FILL  | accepting beats, in_ready high
// PAD   | shifting in zero beats after an early in_last
// FULL  | wavefront presented on out_*, held until out_ready
module alu_wave_gather
  import alu_wave_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANES     = 16,
  parameter int PASSES    = 4,
  parameter int MASK_ZERO = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*WIDTH-1:0]          in_data,
  input  logic [LANES-1:0]                in_mask,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PASSES*LANES*WIDTH-1:0]   out_data,
  output logic [PASSES*LANES-1:0]         out_mask,
  output logic [beat_cnt_w(PASSES)-1:0]   beat_cnt,
  output logic                            err_overrun
);

  localparam int CNT_W = beat_cnt_w(PASSES);
  localparam int LW    = LANES * WIDTH;
  localparam int SW    = LANES * (WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PASSES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             shift;
  logic [LW-1:0]    beat_data;
  logic [SW-1:0]    new_slot;
  logic [SW-1:0]    slot_d [PASSES];
  logic [SW-1:0]    slot_q [PASSES];

  always_comb begin
    beat_data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (MASK_ZERO != 0 && !in_mask[l]) beat_data[l*WIDTH +: WIDTH] = '0;
      else                               beat_data[l*WIDTH +: WIDTH] = in_data[l*WIDTH +: WIDTH];
    end
  end

  assign new_slot = (state == PAD) ? '0 : {in_mask, beat_data};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    shift     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          shift   = 1'b1;
          cnt_nxt = beat_cnt + CNT_ONE;
          // A full count wins over in_last: no padding is needed.
          if (cnt_nxt == CNT_FULL) state_nxt = FULL;
          else if (in_last)        state_nxt = PAD;
        end
      end
      PAD: begin
        shift   = 1'b1;
        cnt_nxt = beat_cnt + CNT_ONE;
        if (cnt_nxt == CNT_FULL) state_nxt = FULL;
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      if (in_valid && (state == FULL || state == PAD)) err_overrun <= 1'b1;
    end
  end

  for (genvar k = 0; k < PASSES; k++) begin : g_slot
    if (k == PASSES - 1) begin : g_tail
      assign slot_d[k] = new_slot;
    end else begin : g_body
      assign slot_d[k] = slot_q[k+1];
    end

    alu_wave_gather_reg #(.W(SW)) u_slot (
      .clk (clk),
      .rst (rst),
      .en  (shift),
      .d   (slot_d[k]),
      .q   (slot_q[k])
    );

    assign out_data[k*LW +: LW]       = slot_q[k][LW-1:0];
    assign out_mask[k*LANES +: LANES] = slot_q[k][SW-1:LW];
  end

endmodule
